unmovebit: RTL and testbench



---
 rtl/unmovebit_pkg.sv | 10 +
 rtl/unmovebit_if.sv | 14 +
 rtl/unmovebit_popcnt.sv | 58 +++++
 rtl/unmovebit.sv | 75 +++++++
 tb/tb_unmovebit.sv | 130 +++++++++++++
 5 files changed

// File: rtl/unmovebit_pkg.sv
// unmovebit_pkg: shared widths, FSM states and the MOVEBIT top-bit mask helper
package unmovebit_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_IMM_W = 16;
  localparam int CNT_W = 5;
  typedef enum logic [1:0] {IDLE, COUNT, SHIFT, FIX} state_t;
  function automatic logic [63:0] top_mask(input logic [CNT_W-1:0] cnt, input int w);
    return ((64'd1 << cnt) - 64'd1) << (w - int'(cnt));
  endfunction
endpackage

// File: rtl/unmovebit_if.sv
// unmovebit_if: start/done handshake and operand/result bus of the unmovebit coprocessor
interface unmovebit_if import unmovebit_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMM_W = DEF_IMM_W
);
  logic start;
  logic [DATA_W-1:0] din;
  logic [IMM_W-1:0] imm16;
  logic busy;
  logic done;
  logic [DATA_W-1:0] dout;
  modport master (output start, din, imm16, input busy, done, dout);
  modport slave (input start, din, imm16, output busy, done, dout);
endinterface

// File: rtl/unmovebit_popcnt.sv
// unmovebit_popcnt: immediate popcount, one bit per step by default, single-cycle under UNMOVEBIT_FAST_EN
module unmovebit_popcnt import unmovebit_pkg::*; #(
  parameter int IMM_W = DEF_IMM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [IMM_W-1:0] imm_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_nx_o,
  output logic             last_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef UNMOVEBIT_FAST_EN
  logic unused_step;
  assign unused_step = step_i;
  assign last_o = 1'b1;
  // Whole count computed from the live immediate and captured on load
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
      for (int i = 0; i < IMM_W; i++) cnt_d = cnt_d + CNT_W'(imm_i[i]);
    end
  end
  // Count register
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  localparam int IDX_W = $clog2(IMM_W);
  logic [IMM_W-1:0] imm_q, imm_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  assign last_o = idx_q == IDX_W'(IMM_W - 1);
  // Load latches the immediate and clears; each step adds one immediate bit
  always_comb begin
    imm_d = load_i ? imm_i : imm_q;
    idx_d = load_i ? '0 : step_i ? idx_q + 1'b1 : idx_q;
    cnt_d = load_i ? '0 : step_i ? cnt_q + CNT_W'(imm_q[idx_q]) : cnt_q;
  end
  // Immediate latch, bit index and running count
  always_ff @(posedge clk) begin
    if (!reset) begin
      imm_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      imm_q <= imm_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end
`endif
  assign cnt_o = cnt_q;
  assign cnt_nx_o = cnt_d;
endmodule

// File: rtl/unmovebit.sv
// unmovebit: reconstructs (din << c) ^ top-c mask, c = popcount(imm16); UNMOVEBIT_FAST_EN skips the serial count
module unmovebit import unmovebit_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMM_W = DEF_IMM_W
) (
  input logic       clk,
  input logic       reset,
  unmovebit_if.slave bus
);
  state_t state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d, dout_q, dout_d;
  logic [CNT_W-1:0] sh_q, sh_d, cnt, cnt_nx;
  logic done_q, done_d, last, load, step;
  assign load = state_q == IDLE && bus.start;
  assign step = state_q == COUNT;
  unmovebit_popcnt #(.IMM_W(IMM_W)) u_popcnt (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load),
    .step_i   (step),
    .imm_i    (bus.imm16),
    .cnt_o    (cnt),
    .cnt_nx_o (cnt_nx),
    .last_o   (last)
  );
  // Next state: accept, count, shift c times, then apply the mask and publish
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    sh_d = sh_q;
    dout_d = dout_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        acc_d = bus.din;
        sh_d = '0;
`ifdef UNMOVEBIT_FAST_EN
        state_d = cnt_nx == '0 ? FIX : SHIFT;
`else
        state_d = COUNT;
`endif
      end
      COUNT: if (last) state_d = cnt_nx == '0 ? FIX : SHIFT;
      SHIFT: begin
        acc_d = acc_q << 1;
        sh_d = sh_q + 1'b1;
        state_d = sh_d == cnt ? FIX : SHIFT;
      end
      default: begin
        dout_d = acc_q ^ DATA_W'(top_mask(cnt, DATA_W));
        done_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  // State, accumulator and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      sh_q <= '0;
      dout_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      sh_q <= sh_d;
      dout_q <= dout_d;
      done_q <= done_d;
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.dout = dout_q;
endmodule

// File: tb/tb_unmovebit.sv
// tb_unmovebit: directed checks of unmovebit results, latency, busy/done handshake and reset abort
module tb_unmovebit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_assert = 0;
  int n_fail = 0;
  int n;
  int dones;
`ifdef UNMOVEBIT_FAST_EN
  localparam int BASE = 1;
`else
  localparam int BASE = 17;
`endif
  always #5 clk = ~clk;
  unmovebit_if bus ();
  unmovebit dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] d, input logic [15:0] i);
    bus.start = 1'b1;
    bus.din = d;
    bus.imm16 = i;
    step();
    bus.start = 1'b0;
    bus.din = $urandom;
    bus.imm16 = 16'($urandom);
    check("busy_after_accept", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] d, input logic [15:0] i, input int c,
                     input logic [31:0] exp);
    int cyc;
    issue(d, i);
    wait_done(cyc);
    check({tag, "_latency"}, 32'(cyc), 32'(BASE + c));
    check({tag, "_dout"}, bus.dout, exp);
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    step();
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_dout_hold"}, bus.dout, exp);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.din = '0;
    bus.imm16 = '0;
    step();
    step();
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_dout", bus.dout, 32'd0);
    reset = 1'b1;
    step();
    run("c4", 32'hFE234567, 16'h000F, 4, 32'h12345670);
    run("c0", 32'hDEADBEEF, 16'h0000, 0, 32'hDEADBEEF);
    run("c16", 32'h00001234, 16'hFFFF, 16, 32'hEDCB0000);
    issue(32'h40000003, 16'h0001);
    dones = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 3 || k == 10) begin
        bus.start = 1'b1;
        bus.din = 32'h0000FFFF;
        bus.imm16 = 16'h0003;
      end
      step();
      bus.start = 1'b0;
      if (bus.done === 1'b1) dones++;
    end
`ifdef UNMOVEBIT_FAST_EN
    check("busy_start_dones", 32'(dones), 32'd3);
    check("busy_start_dout", bus.dout, 32'hC003FFFC);
`else
    check("busy_start_dones", 32'(dones), 32'd1);
    check("busy_start_dout", bus.dout, 32'h00000006);
`endif
    issue(32'h00000001, 16'h0101);
    wait_done(n);
    check("b2b_first_latency", 32'(n), 32'(BASE + 2));
    check("b2b_first_dout", bus.dout, 32'hC0000004);
    bus.start = 1'b1;
    bus.din = 32'h12345678;
    bus.imm16 = 16'h0007;
    step();
    bus.start = 1'b0;
    check("b2b_busy", 32'(bus.busy), 32'd1);
    check("b2b_done_low", 32'(bus.done), 32'd0);
    wait_done(n);
    check("b2b_second_latency", 32'(n), 32'(BASE + 3));
    check("b2b_second_dout", bus.dout, 32'h71A2B3C0);
    step();
    issue(32'h00001234, 16'hFFFF);
    repeat (BASE + 1) step();
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    step();
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_dout", bus.dout, 32'd0);
    reset = 1'b1;
    dones = 0;
    repeat (40) begin
      step();
      if (bus.done === 1'b1) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    run("after_abort", 32'hFE234567, 16'h000F, 4, 32'h12345670);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
